// File: rtl/sfx_sequencer.sv
// One-shot sound-effect sequencer: captures a packed multi-step tone sequence on
// trigger and plays each step for T_STEP cycles, with optional retrigger and abort.
module sfx_sequencer #(
   parameter logic [31:0] MAIN_CLK_SPEED = 32'd12_288_000,
   parameter int          CHANNELS       = 4,
   parameter int          TONE_W         = 4,
   parameter int          STEPS          = 4,
   parameter int          STEP_DIV       = 10,
   parameter int          RETRIGGER      = 0,
   localparam int         CW             = CHANNELS * TONE_W,
   localparam int         SW             = (STEPS > 1) ? $clog2(STEPS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  send,
   input  logic                  stop,
   input  logic [STEPS*CW-1:0]   sfx,
   output logic [CW-1:0]         tones,
   output logic [SW-1:0]         step,
   output logic                  busy,
   output logic                  done
);

   localparam logic [31:0]   T_STEP    = MAIN_CLK_SPEED / STEP_DIV;
   localparam logic [31:0]   T_LAST    = T_STEP - 32'd1;
   localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PLAY         = 2'd1,
      WAIT_RELEASE = 2'd2
   } state_t;

   state_t                state, state_n;
   logic [STEPS*CW-1:0]   snapshot, snapshot_n;
   logic [SW-1:0]         step_cnt, step_n;
   logic [31:0]           tick, tick_n;
   logic                  send_q;
   logic                  done_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         snapshot <= '0;
         step_cnt <= '0;
         tick     <= '0;
         send_q   <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         snapshot <= snapshot_n;
         step_cnt <= step_n;
         tick     <= tick_n;
         send_q   <= send;
         done     <= done_n;
      end
   end

   always_comb begin
      state_n    = state;
      snapshot_n = snapshot;
      step_n     = step_cnt;
      tick_n     = tick;
      done_n     = 1'b0;
      case (state)
         IDLE: begin
            if (send) begin
               snapshot_n = sfx;
               step_n     = '0;
               tick_n     = '0;
               state_n    = PLAY;
            end
         end
         PLAY: begin
            // A retrigger edge outranks completion in the same cycle.
            if ((RETRIGGER != 0) && send && !send_q) begin
               snapshot_n = sfx;
               step_n     = '0;
               tick_n     = '0;
            end else if (tick == T_LAST) begin
               tick_n = '0;
               if (step_cnt == LAST_STEP) begin
                  step_n  = '0;
                  done_n  = 1'b1;
                  state_n = send ? WAIT_RELEASE : IDLE;
               end else begin
                  step_n = step_cnt + SW'(1);
               end
            end else begin
               tick_n = tick + 32'd1;
            end
         end
         WAIT_RELEASE: begin
            if (!send) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      if (stop) begin
         state_n = send ? WAIT_RELEASE : IDLE;
         step_n  = '0;
         tick_n  = '0;
         done_n  = 1'b0;
      end
   end

   always_comb begin
      tones = '0;
      if (state == PLAY) begin
         for (int unsigned k = 0; k < STEPS; k++) begin
            if (step_cnt == SW'(k)) tones = snapshot[(STEPS-k)*CW-1 -: CW];
         end
      end
   end

   assign step = (state == PLAY) ? step_cnt : '0;
   assign busy = (state == PLAY);

endmodule

// File: tb/tb_sfx_sequencer.sv
// Bench for sfx_sequencer: two instances (retrigger off/on) share stimulus and are
// checked each cycle against an elapsed-cycle reference model plus explicit vectors.
module tb_sfx_sequencer;

   logic        clk;
   logic        reset;
   logic        send;
   logic        stop;
   logic [63:0] sfx;
   logic [15:0] tones0, tones1;
   logic [1:0]  step0, step1;
   logic        busy0, busy1, done0, done1;

   int checks = 0;
   int errors = 0;

   sfx_sequencer #(
      .MAIN_CLK_SPEED(32'd100), .CHANNELS(4), .TONE_W(4),
      .STEPS(4), .STEP_DIV(10), .RETRIGGER(0)
   ) dut0 (
      .clk(clk), .reset(reset), .send(send), .stop(stop), .sfx(sfx),
      .tones(tones0), .step(step0), .busy(busy0), .done(done0)
   );

   sfx_sequencer #(
      .MAIN_CLK_SPEED(32'd100), .CHANNELS(4), .TONE_W(4),
      .STEPS(4), .STEP_DIV(10), .RETRIGGER(1)
   ) dut1 (
      .clk(clk), .reset(reset), .send(send), .stop(stop), .sfx(sfx),
      .tones(tones1), .step(step1), .busy(busy1), .done(done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] tones;
      logic [1:0]  step;
      logic        busy;
      logic        done;
   } obs_t;

   obs_t q0[$];
   obs_t q1[$];

   // Reference model: one elapsed-cycle count per instance instead of step/tick.
   bit          m_act[2];
   bit          m_wait[2];
   bit          m_done[2];
   logic [63:0] m_snap[2];
   int          m_el[2];
   bit          m_sendq;

   task automatic model_reset();
      for (int r = 0; r < 2; r++) begin
         m_act[r] = 0; m_wait[r] = 0; m_done[r] = 0; m_snap[r] = '0; m_el[r] = 0;
      end
      m_sendq = 0;
   endtask

   function automatic obs_t exp_of(int r);
      obs_t        o;
      logic [63:0] sh;
      o = '0;
      if (m_act[r]) begin
         sh      = m_snap[r] >> (48 - 16 * (m_el[r] / 10));
         o.tones = sh[15:0];
         o.step  = 2'(m_el[r] / 10);
         o.busy  = 1'b1;
      end
      o.done = m_done[r];
      return o;
   endfunction

   task automatic predict(input logic s, input logic p, input logic [63:0] x);
      for (int r = 0; r < 2; r++) begin
         m_done[r] = 0;
         if (p) begin
            m_act[r] = 0; m_wait[r] = s; m_el[r] = 0;
         end else if (m_act[r]) begin
            if (r == 1 && s && !m_sendq) begin
               m_snap[r] = x; m_el[r] = 0;
            end else if (m_el[r] == 39) begin
               m_act[r] = 0; m_wait[r] = s; m_done[r] = 1; m_el[r] = 0;
            end else begin
               m_el[r]++;
            end
         end else if (m_wait[r]) begin
            m_wait[r] = s;
         end else if (s) begin
            m_act[r] = 1; m_snap[r] = x; m_el[r] = 0;
         end
      end
      m_sendq = s;
      q0.push_back(exp_of(0));
      q1.push_back(exp_of(1));
   endtask

   task automatic chk_obs(string name, obs_t act, obs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got tones=%h step=%0d busy=%b done=%b, expected tones=%h step=%0d busy=%b done=%b",
                  name, act.tones, act.step, act.busy, act.done, exp.tones, exp.step, exp.busy, exp.done);
      end
   endtask

   task automatic chk_val(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive inputs at the sample point, clock once, then compare against the scoreboard.
   task automatic cycle(input logic s, input logic p, input logic [63:0] x);
      send = s; stop = p; sfx = x;
      predict(s, p, x);
      @(posedge clk);
      #1;
      if (q0.size() == 0 || q1.size() == 0) begin
         checks++; errors++;
         $display("FAIL sb_empty: got empty queue expected entry");
      end else begin
         chk_obs("sb_r0", {tones0, step0, busy0, done0}, q0.pop_front());
         chk_obs("sb_r1", {tones1, step1, busy1, done1}, q1.pop_front());
      end
   endtask

   typedef struct {
      logic        send;
      logic        stop;
      logic [63:0] sfx;
      int          n;
      logic [15:0] tones;
      logic [1:0]  step;
      logic        busy;
      logic        done;
   } vec_t;

   localparam logic [63:0] SFX_A = 64'h1234_5678_9ABC_DEF0;
   localparam logic [63:0] SFX_F = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] SFX_B = 64'hCAFE_0001_0002_0003;
   localparam logic [63:0] SFX_C = 64'h4321_0000_0000_0000;

   vec_t tbl[9];

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int busy_cnt, done_cnt, done0_cnt;

      tbl[0] = '{1'b0, 1'b0, SFX_A, 1,  16'h0000, 2'd0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, SFX_A, 1,  16'h1234, 2'd0, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 1'b0, SFX_F, 9,  16'h1234, 2'd0, 1'b1, 1'b0};
      tbl[3] = '{1'b0, 1'b0, SFX_F, 1,  16'h5678, 2'd1, 1'b1, 1'b0};
      tbl[4] = '{1'b0, 1'b0, SFX_F, 10, 16'h9ABC, 2'd2, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 1'b0, SFX_F, 10, 16'hDEF0, 2'd3, 1'b1, 1'b0};
      tbl[6] = '{1'b0, 1'b0, SFX_F, 9,  16'hDEF0, 2'd3, 1'b1, 1'b0};
      tbl[7] = '{1'b0, 1'b0, SFX_F, 1,  16'h0000, 2'd0, 1'b0, 1'b1};
      tbl[8] = '{1'b0, 1'b0, SFX_F, 1,  16'h0000, 2'd0, 1'b0, 1'b0};

      reset = 1'b1; send = 1'b0; stop = 1'b0; sfx = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_obs("reset_held_r0", {tones0, step0, busy0, done0}, '0);
      chk_obs("reset_held_r1", {tones1, step1, busy1, done1}, '0);
      #2 reset = 1'b0;
      @(posedge clk);
      #1;
      chk_obs("reset_rel_r0", {tones0, step0, busy0, done0}, '0);

      // Basic playback; sfx switches to all-ones mid-playback and must be ignored.
      for (int i = 0; i < 9; i++) begin
         for (int j = 0; j < tbl[i].n; j++) cycle(tbl[i].send, tbl[i].stop, tbl[i].sfx);
         chk_obs($sformatf("vec%0d_r0", i), {tones0, step0, busy0, done0},
                 {tbl[i].tones, tbl[i].step, tbl[i].busy, tbl[i].done});
         chk_obs($sformatf("vec%0d_r1", i), {tones1, step1, busy1, done1},
                 {tbl[i].tones, tbl[i].step, tbl[i].busy, tbl[i].done});
      end

      // Held send: one playback only, then parked until release.
      busy_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         cycle(1'b1, 1'b0, SFX_A);
         busy_cnt += busy0;
         done_cnt += done0;
      end
      chk_val("hold_busy_cycles", busy_cnt, 40);
      chk_val("hold_done_pulses", done_cnt, 1);
      cycle(1'b0, 1'b0, SFX_A);
      chk_val("hold_release_idle", busy0, 0);
      cycle(1'b1, 1'b0, SFX_C);
      chk_val("hold_replay_tones", tones0, 16'h4321);
      for (int i = 0; i < 45; i++) cycle(1'b0, 1'b0, SFX_C);

      // Retrigger edge at step 2 tick 5.
      cycle(1'b1, 1'b0, SFX_A);
      for (int i = 0; i < 25; i++) cycle(1'b0, 1'b0, SFX_A);
      cycle(1'b1, 1'b0, SFX_B);
      chk_val("retrig_r1_step", step1, 0);
      chk_val("retrig_r1_tones", tones1, 16'hCAFE);
      chk_val("retrig_r0_step", step0, 2);
      chk_val("retrig_r0_tones", tones0, 16'h9ABC);
      busy_cnt = 1; done_cnt = 0; done0_cnt = 0;
      for (int i = 0; i < 50; i++) begin
         cycle(1'b0, 1'b0, SFX_B);
         busy_cnt  += busy1;
         done_cnt  += done1;
         done0_cnt += done0;
      end
      chk_val("retrig_r1_busy_cycles", busy_cnt, 40);
      chk_val("retrig_r1_done_pulses", done_cnt, 1);
      chk_val("retrig_r0_done_pulses", done0_cnt, 1);

      // Stop during step 1.
      cycle(1'b1, 1'b0, SFX_A);
      for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0, SFX_A);
      chk_val("stop_pre_step", step0, 1);
      cycle(1'b0, 1'b1, SFX_A);
      chk_obs("stop_r0", {tones0, step0, busy0, done0}, '0);
      done_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, SFX_A);
         done_cnt += done0 + done1;
      end
      chk_val("stop_no_done", done_cnt, 0);
      cycle(1'b1, 1'b0, SFX_C);
      chk_obs("stop_restart_r0", {tones0, step0, busy0, done0}, {16'h4321, 2'd0, 1'b1, 1'b0});
      for (int i = 0; i < 45; i++) cycle(1'b0, 1'b0, SFX_C);

      // Async reset between edges during playback.
      cycle(1'b1, 1'b0, SFX_A);
      for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, SFX_A);
      #3 reset = 1'b1;
      #1;
      chk_obs("async_rst_r0", {tones0, step0, busy0, done0}, '0);
      chk_obs("async_rst_r1", {tones1, step1, busy1, done1}, '0);
      model_reset();
      @(posedge clk);
      #2 reset = 1'b0;
      cycle(1'b0, 1'b0, SFX_A);
      chk_val("post_rst_idle", busy0 | busy1, 0);
      cycle(1'b1, 1'b0, SFX_B);
      chk_obs("post_rst_start_r0", {tones0, step0, busy0, done0}, {16'hCAFE, 2'd0, 1'b1, 1'b0});
      for (int i = 0; i < 45; i++) cycle(1'b0, 1'b0, SFX_B);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sfx_sequencer.md
# sfx_sequencer

Parametrised one-shot sound-effect sequencer. It feeds the tone generators of the synth voice path with a short multi-step effect when triggered. On a trigger it captures a packed sequence of STEPS steps, each holding CHANNELS tone codes, and plays the steps in order for a fixed duration each. Optional retrigger and abort are supported. It replaces the single-step, fixed-4-channel one-shot in the voice front end.

## Interface
- MAIN_CLK_SPEED, 32'd12_288_000: clk frequency in Hz.
- CHANNELS, 4: number of tone channels driven.
- TONE_W, 4: bits per tone code.
- STEPS, 4: steps per effect (≥1).
- STEP_DIV, 10: step length T_STEP = MAIN_CLK_SPEED / STEP_DIV cycles (integer divide; T_STEP ≥ 1 required).
- RETRIGGER, 0: 1 = a rising edge of send during PLAY restarts the effect.

Derived: CW = CHANNELS*TONE_W; SW = max(1, $clog2(STEPS)).

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- send  in  1  trigger level (button/command), synchronous to clk.
- stop  in  1  synchronous abort, 1-cycle pulse or level.
- sfx  in  STEPS*CW  packed sequence; step k = sfx[(STEPS-k)*CW-1 -: CW]; within a step, channel c = bits [CW-1-c*TONE_W -: TONE_W] (step 0 and channel 0 at the MSBs).
- tones  out  CW  current tone codes, channel 0 at the MSBs; all zero when not playing.
- step  out  SW  index of the step being played; 0 when not playing.
- busy  out  1  high exactly while in PLAY.
- done  out  1  one-cycle pulse on natural completion of the last step.

## Operation
- States: IDLE, PLAY, WAIT_RELEASE (2-bit encoding; unused code → IDLE).
- Registers: state, snapshot (STEPS*CW), step counter, tick counter (32-bit), send_q (previous send), done.
- IDLE: if send=1, capture sfx into snapshot, clear step and tick counters, go to PLAY. Otherwise hold.
- PLAY: tones = snapshot step[step]. tick increments each cycle.
  - When tick = T_STEP-1, tick clears and step increments.
  - If step = STEPS-1 when tick = T_STEP-1, the effect ends. Next state is WAIT_RELEASE if send=1, else IDLE. done pulses.
- WAIT_RELEASE: if send=0, go to IDLE. Blocks auto-repeat while send is held.
- Retrigger (RETRIGGER=1 only): in PLAY, send=1 and send_q=0 → recapture sfx, step=0, tick=0, stay in PLAY. No done pulse. With RETRIGGER=0, send edges in PLAY are ignored.
- stop=1 in any state → next state WAIT_RELEASE if send=1, else IDLE. Counters clear and no done pulse. stop has priority over retrigger, completion and trigger.
- Completion and a retrigger edge in the same cycle: retrigger wins, no done.
- The snapshot is the only source of tones. Changing sfx during PLAY has no effect.
- tones, step and busy are combinational from registered state only, so they are glitch-free relative to clk. done is a register.

## Timing
- Reset (async assert, sync release): state=IDLE, snapshot=0, step=0, tick=0, send_q=0, done=0. Therefore tones=0, step=0, busy=0, done=0.
- Trigger latency: send high at clock edge N (in IDLE) → busy=1 and tones = step 0 from cycle N+1.
- Each step is presented for exactly T_STEP cycles. Total PLAY duration is STEPS*T_STEP cycles.
- done is high in the first cycle after the last PLAY cycle. busy=0 in that same cycle.
- Minimum gap between effects: one cycle in IDLE/WAIT_RELEASE with send=0 before a new trigger is accepted.
- The retrigger restart is visible one cycle after the edge. The new step 0 lasts a full T_STEP.
- stop takes effect on the next edge. busy and tones go to 0 one cycle later.

## Test plan
Bench parameters: MAIN_CLK_SPEED=100, STEP_DIV=10 (T_STEP=10), STEPS=4, CHANNELS=4, TONE_W=4.

1. Reset held, then released, with send=0 → tones=0, step=0, busy=0, done=0. Drive sfx=64'h1234_5678_9ABC_DEF0 and pulse send for 1 cycle → tones shows 16'h1234 for 10 cycles, then 5678, then 9ABC, then DEF0. done pulses 1 cycle after cycle 40 of busy. State returns to IDLE.
2. Hold send high for 100 cycles → exactly one 40-cycle playback, then WAIT_RELEASE with tones=0. No replay until send drops and rises again.
3. Change sfx to 64'hFFFF_FFFF_FFFF_FFFF mid-playback → output continues with the captured values (unchanged from scenario 1).
4. RETRIGGER=1: new send rising edge at tick 5 of step 2 → next cycle step=0, tones = new step 0, and a full 40 cycles follow. No done for the aborted run. With RETRIGGER=0 the same stimulus → playback unaffected.
5. stop pulse in step 1 with send=0 → next cycle busy=0, tones=0, no done, state IDLE. A later send starts cleanly at step 0.
6. Async reset asserted mid-PLAY, between edges → outputs zero immediately. After release, IDLE with send ignored until sampled high.
